// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt capture/arbitration path.
// Holds the arbiter FSM state type, the default request count and the
// index-width derivation used by the top and the priority encoder.
package irq_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Index width for n request lines; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : 32'($clog2(n));
  endfunction

endpackage : irq_pkg

// File: rtl/prio_enc.sv
// Combinational priority encoder: highest set bit wins.
// Ports:
//   in_vec  [N-1:0]      candidate request vector
//   idx_c   [IDX_W-1:0]  index of the highest set bit (0 when none set)
//   any_c                at least one bit of in_vec is set
module prio_enc
  import irq_pkg::*;
#(
  parameter  int unsigned N     = N_DEFAULT,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     in_vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Ascending scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        idx_c = IDX_W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule : prio_enc

// File: rtl/irq_capture_arbiter.sv
// Edge-captures N request lines into sticky pending bits and presents the
// highest pending index through a valid/ack handshake.
// Optional build macro: IRQ_MASK_EN adds a mask input that hides bits from
// selection (they still capture and can overflow).
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req      [N-1:0]     level request lines, rising edges captured
//   en                   capture/arbitration enable
//   ack                  consumer accepts the presented index
//   mask     [N-1:0]     (IRQ_MASK_EN only) selection mask, 1 = hidden
//   y        [IDX_W-1:0] presented index, held while valid
//   valid                y is valid
//   pending  [N-1:0]     sticky pending vector
//   overflow             sticky: edge seen on an already-pending line
module irq_capture_arbiter
  import irq_pkg::*;
#(
  parameter  int unsigned N     = N_DEFAULT,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             ack,
`ifdef IRQ_MASK_EN
  input  logic [N-1:0]     mask,
`endif
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [N-1:0]     req_d_q, req_d_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  logic [N-1:0]     edge_c;
  logic [N-1:0]     clr_c;
  logic [N-1:0]     eligible_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic             sel_any_c;

  // Candidates for the next grant.
`ifdef IRQ_MASK_EN
  assign eligible_c = pending_q & ~mask;
`else
  assign eligible_c = pending_q;
`endif

  prio_enc #(.N(N)) u_prio_enc (
    .in_vec (eligible_c),
    .idx_c  (sel_idx_c),
    .any_c  (sel_any_c)
  );

  // Edge capture, served-bit clear and overflow tracking.
  always_comb begin
    edge_c     = req & ~req_d_q;
    clr_c      = (state_q == PRESENT && ack) ? (N'(1) << y_q) : '0;
    req_d_d    = req;
    // Clearing is tied to the handshake, so an ack still retires the
    // grant while capture is disabled; a same-cycle edge re-sets the bit.
    pending_d  = pending_q & ~clr_c;
    overflow_d = overflow_q;
    if (en) begin
      pending_d  = pending_d | edge_c;
      overflow_d = overflow_q | (|(edge_c & pending_q & ~clr_c));
    end
  end

  // Grant FSM: the presented index is frozen until acked.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (en && sel_any_c) begin
          y_d     = sel_idx_c;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_d_q    <= '0;
      pending_q  <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_d_q    <= req_d_d;
      pending_q  <= pending_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign y        = y_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule : irq_capture_arbiter

// File: tb/tb_irq_capture_arbiter.sv
// Directed bench for irq_capture_arbiter (N=8). Expected grant indices are
// queued as requests are driven and popped when the DUT presents a grant.
module tb_irq_capture_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       ack;
`ifdef IRQ_MASK_EN
  logic [7:0] mask;
`endif
  logic [2:0] y;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_q[$];

  irq_capture_arbiter #(.N(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .ack      (ack),
`ifdef IRQ_MASK_EN
    .mask     (mask),
`endif
    .y        (y),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One-cycle request pulse.
  task automatic pulse(input logic [7:0] v);
    req = v;
    tick();
    req = 8'h00;
  endtask

  // Wait (bounded) for a grant, compare against the scoreboard, ack it and
  // check the mandatory valid=0 cycle that follows.
  task automatic serve(input string tag);
    int unsigned cyc;
    logic [31:0] exp_y;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    exp_y = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_y"}, 32'(y), exp_y);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_gap"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    en  = 1'b0;
    ack = 1'b0;
`ifdef IRQ_MASK_EN
    mask = 8'h00;
`endif
    #12;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // 1: single request, latency check
    exp_q.push_back(2);
    pulse(8'h04);
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_valid_early", 32'(valid), 32'd0);
    tick();
    chk("t1_valid_lat", 32'(valid), 32'd1);
    serve("t1");
    chk("t1_pending_end", 32'(pending), 32'h00);

    // 2: three simultaneous edges, served MSB first
    exp_q.push_back(4);
    exp_q.push_back(2);
    exp_q.push_back(1);
    pulse(8'h16);
    chk("t2_pending", 32'(pending), 32'h16);
    serve("t2a");
    serve("t2b");
    serve("t2c");
    chk("t2_pending_end", 32'(pending), 32'h00);

    // 3: higher-priority arrival does not preempt a presented grant
    exp_q.push_back(2);
    pulse(8'h04);
    tick();
    pulse(8'h80);
    chk("t3_hold_valid", 32'(valid), 32'd1);
    chk("t3_hold_y", 32'(y), 32'd2);
    chk("t3_pending", 32'(pending), 32'h84);
    serve("t3a");
    exp_q.push_back(7);
    serve("t3b");
    chk("t3_pending_end", 32'(pending), 32'h00);
    chk("t3_no_ovf", 32'(overflow), 32'd0);

    // 4a: edge on the bit being acked -> stays pending, no overflow
    pulse(8'h20);
    tick();
    chk("t4a_y", 32'(y), 32'd5);
    req = 8'h20;
    ack = 1'b1;
    tick();
    req = 8'h00;
    ack = 1'b0;
    chk("t4a_pending", 32'(pending), 32'h20);
    chk("t4a_overflow", 32'(overflow), 32'd0);
    chk("t4a_valid", 32'(valid), 32'd0);
    exp_q.push_back(5);
    serve("t4a");

    // 4b: edge on an already-pending, unacked line -> sticky overflow
    pulse(8'h08);
    tick();
    pulse(8'h08);
    chk("t4b_overflow", 32'(overflow), 32'd1);
    tick();
    chk("t4b_overflow_sticky", 32'(overflow), 32'd1);
    exp_q.push_back(3);
    serve("t4b");
    chk("t4b_overflow_after", 32'(overflow), 32'd1);
    chk("t4b_pending_end", 32'(pending), 32'h00);

    // 5a: capture disabled drops edges
    en = 1'b0;
    pulse(8'h41);
    tick();
    chk("t5_pending_dis", 32'(pending), 32'h00);
    chk("t5_valid_dis", 32'(valid), 32'd0);
    en = 1'b1;
    tick();
    chk("t5_pending_reen", 32'(pending), 32'h00);

    // 5b: asynchronous reset during a grant, req held across release
    pulse(8'h02);
    tick();
    chk("t5_valid_pre", 32'(valid), 32'd1);
    req = 8'h10;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(valid), 32'd0);
    chk("t5_async_y", 32'(y), 32'd0);
    chk("t5_async_pending", 32'(pending), 32'd0);
    chk("t5_async_overflow", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    exp_q.push_back(4);
    tick();
    chk("t5_captured", 32'(pending), 32'h10);
    serve("t5");
    tick();
    tick();
    chk("t5_once_pending", 32'(pending), 32'h00);
    chk("t5_once_valid", 32'(valid), 32'd0);
    req = 8'h00;
    tick();

`ifdef IRQ_MASK_EN
    // 6: masked bit stays pending and is never presented until unmasked
    mask = 8'h80;
    exp_q.push_back(0);
    pulse(8'h81);
    serve("t6a");
    chk("t6_pending_masked", 32'(pending), 32'h80);
    tick();
    tick();
    tick();
    chk("t6_no_grant", 32'(valid), 32'd0);
    mask = 8'h00;
    exp_q.push_back(7);
    serve("t6b");
    chk("t6_pending_end", 32'(pending), 32'h00);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_irq_capture_arbiter
